// File: rtl/case_6_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module   : case_6_mac_accum
//  Purpose  : Accumulates a stream of signed products into frame sums. A frame
//             closes on FRAME_LEN beats or on prod_last, whichever comes first.
//             Each sum is presented on a valid/ready holding register together
//             with its beat count and a per-frame overflow flag.
//  Ports    : ap_clk, ap_rst (async, active-high)
//             prod_data/prod_vld/prod_last/prod_rdy : product input stream
//             acc_data/acc_cnt/acc_ovf/acc_vld/acc_rdy : frame result output
//  Config   : CASE6_MAC_SATURATE_EN defined -> overflowing sums clamp to the
//             ACC_WIDTH signed max/min; undefined -> sums wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module case_6_mac_accum #(
  parameter int PROD_WIDTH = 26,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 8,
  parameter int FRAME_LEN  = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [PROD_WIDTH-1:0] prod_data,
  input  logic                  prod_vld,
  input  logic                  prod_last,
  output logic                  prod_rdy,
  output logic [ACC_WIDTH-1:0]  acc_data,
  output logic [CNT_WIDTH-1:0]  acc_cnt,
  output logic                  acc_ovf,
  output logic                  acc_vld,
  input  logic                  acc_rdy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FRAME_LEN - 1);
`ifdef CASE6_MAC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  logic [1:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_sticky_q, ovf_sticky_d;
  logic [ACC_WIDTH-1:0] acc_data_q, acc_data_d;
  logic [CNT_WIDTH-1:0] acc_cnt_q, acc_cnt_d;
  logic                 acc_ovf_q, acc_ovf_d;
  logic                 acc_vld_q, acc_vld_d;

  logic                 beat;
  logic                 close;
  logic [ACC_WIDTH:0]   prod_ext;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 sum_ovf;
  logic [ACC_WIDTH-1:0] sum_next;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_ACC;
      ST_ACC:  if (close) state_d = ST_HOLD;
      ST_HOLD: if (acc_vld_q && acc_rdy) state_d = ST_ACC;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode: registered state only, so prod_rdy has no input paths
  // ---------------------------------------------------------------------------
  always_comb begin
    prod_rdy = (state_q == ST_ACC);
  end

  // ---------------------------------------------------------------------------
  // Datapath: one extra bit of headroom makes overflow a simple top-bit compare
  // ---------------------------------------------------------------------------
  assign beat  = prod_vld & prod_rdy;
  assign close = beat & (prod_last | (cnt_q == CNT_LAST));

  always_comb begin
    prod_ext = {{(ACC_WIDTH + 1 - PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    sum_ext  = {acc_q[ACC_WIDTH-1], acc_q} + prod_ext;
    sum_ovf  = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
`ifdef CASE6_MAC_SATURATE_EN
    // The extended sign bit tells which rail was crossed.
    if (sum_ovf) begin
      sum_next = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end else begin
      sum_next = sum_ext[ACC_WIDTH-1:0];
    end
`else
    sum_next = sum_ext[ACC_WIDTH-1:0];
`endif
  end

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    acc_data_d   = acc_data_q;
    acc_cnt_d    = acc_cnt_q;
    acc_ovf_d    = acc_ovf_q;
    acc_vld_d    = acc_vld_q;
    if (close) begin
      // Result includes the closing beat; running state restarts at zero.
      acc_data_d   = sum_next;
      acc_cnt_d    = cnt_q + CNT_ONE;
      acc_ovf_d    = ovf_sticky_q | sum_ovf;
      acc_vld_d    = 1'b1;
      acc_d        = '0;
      cnt_d        = '0;
      ovf_sticky_d = 1'b0;
    end else if (beat) begin
      acc_d        = sum_next;
      cnt_d        = cnt_q + CNT_ONE;
      ovf_sticky_d = ovf_sticky_q | sum_ovf;
    end
    if ((state_q == ST_HOLD) && acc_vld_q && acc_rdy) begin
      acc_vld_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_sticky_q <= 1'b0;
      acc_data_q   <= '0;
      acc_cnt_q    <= '0;
      acc_ovf_q    <= 1'b0;
      acc_vld_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
      acc_data_q   <= acc_data_d;
      acc_cnt_q    <= acc_cnt_d;
      acc_ovf_q    <= acc_ovf_d;
      acc_vld_q    <= acc_vld_d;
    end
  end

  assign acc_data = acc_data_q;
  assign acc_cnt  = acc_cnt_q;
  assign acc_ovf  = acc_ovf_q;
  assign acc_vld  = acc_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_case_6_mac_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_case_6_mac_accum
//  Purpose  : Directed self-checking bench for case_6_mac_accum. A 32-bit and
//             a 28-bit accumulator instance share the same input stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_case_6_mac_accum;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [25:0] prod_data = '0;
  logic        prod_vld = 1'b0;
  logic        prod_last = 1'b0;
  logic        acc_rdy = 1'b1;

  logic        prod_rdy;
  logic [31:0] acc_data;
  logic [7:0]  acc_cnt;
  logic        acc_ovf;
  logic        acc_vld;

  logic        prod_rdy28;
  logic [27:0] acc_data28;
  logic [7:0]  acc_cnt28;
  logic        acc_ovf28;
  logic        acc_vld28;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  case_6_mac_accum dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .prod_data(prod_data), .prod_vld(prod_vld), .prod_last(prod_last), .prod_rdy(prod_rdy),
    .acc_data(acc_data), .acc_cnt(acc_cnt), .acc_ovf(acc_ovf), .acc_vld(acc_vld),
    .acc_rdy(acc_rdy)
  );

  case_6_mac_accum #(.PROD_WIDTH(26), .ACC_WIDTH(28), .CNT_WIDTH(8), .FRAME_LEN(16)) dut28 (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .prod_data(prod_data), .prod_vld(prod_vld), .prod_last(prod_last), .prod_rdy(prod_rdy28),
    .acc_data(acc_data28), .acc_cnt(acc_cnt28), .acc_ovf(acc_ovf28), .acc_vld(acc_vld28),
    .acc_rdy(acc_rdy)
  );

  // Presents one beat from a falling edge and returns just after the rising
  // edge that accepts it. A stuck prod_rdy is reported instead of hanging.
  task automatic send_beat(input logic [25:0] d, input logic last);
    int guard;
    guard = 0;
    @(negedge ap_clk);
    prod_vld  = 1'b1;
    prod_data = d;
    prod_last = last;
    while (prod_rdy !== 1'b1 && guard < 50) begin
      @(negedge ap_clk);
      guard++;
    end
    checks++;
    if (guard >= 50) begin
      errors++;
      $display("FAIL beat_timeout: prod_rdy=%b required 1", prod_rdy);
    end
    @(posedge ap_clk);
  endtask

  // Drops the input stream on the next falling edge, where outputs are sampled.
  task automatic idle_input();
    @(negedge ap_clk);
    prod_vld  = 1'b0;
    prod_last = 1'b0;
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    #3;
    checks++;
    if ({acc_vld, acc_ovf, acc_cnt, acc_data, prod_rdy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b ovf=%b cnt=%0d data=%0d rdy=%b required all 0",
               acc_vld, acc_ovf, acc_cnt, acc_data, prod_rdy);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (prod_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_to_acc: prod_rdy=%b required 1", prod_rdy);
    end
  endtask

  task automatic test_full_frame();
    acc_rdy = 1'b1;
    for (int i = 0; i < 15; i++) send_beat(26'd100, 1'b0);
    #1;
    checks++;
    if (acc_vld !== 1'b0) begin
      errors++;
      $display("FAIL full_early_vld: acc_vld=%b required 0", acc_vld);
    end
    send_beat(26'd100, 1'b0);
    idle_input();
    checks++;
    if (acc_vld !== 1'b1 || acc_data !== 32'd1600 || acc_cnt !== 8'd16 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_result: vld=%b data=%0d cnt=%0d ovf=%b required 1 1600 16 0",
               acc_vld, acc_data, acc_cnt, acc_ovf);
    end
    @(negedge ap_clk);
    checks++;
    if (acc_vld !== 1'b0 || prod_rdy !== 1'b1) begin
      errors++;
      $display("FAIL full_release: vld=%b rdy=%b required 0 1", acc_vld, prod_rdy);
    end
  endtask

  task automatic test_last_close();
    send_beat(-26'sd5, 1'b0);
    send_beat(26'd7, 1'b0);
    send_beat(-26'sd20, 1'b1);
    idle_input();
    checks++;
    if (acc_vld !== 1'b1 || acc_data !== 32'hFFFFFFEE || acc_cnt !== 8'd3 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL last_result: vld=%b data=%h cnt=%0d ovf=%b required 1 ffffffee 3 0",
               acc_vld, acc_data, acc_cnt, acc_ovf);
    end
  endtask

  task automatic test_backpressure();
    @(negedge ap_clk);
    acc_rdy = 1'b0;
    send_beat(26'd3, 1'b0);
    send_beat(26'd4, 1'b1);
    @(negedge ap_clk);
    // Offer a beat throughout the hold; none may be taken.
    prod_vld  = 1'b1;
    prod_data = 26'd1000;
    prod_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (acc_vld !== 1'b1 || acc_data !== 32'd7 || acc_cnt !== 8'd2 || prod_rdy !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d]: vld=%b data=%0d cnt=%0d rdy=%b required 1 7 2 0",
                 i, acc_vld, acc_data, acc_cnt, prod_rdy);
      end
      @(negedge ap_clk);
    end
    prod_vld = 1'b0;
    acc_rdy  = 1'b1;
    @(negedge ap_clk);
    checks++;
    if (prod_rdy !== 1'b1 || acc_vld !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: rdy=%b vld=%b required 1 0", prod_rdy, acc_vld);
    end
    send_beat(26'd5, 1'b1);
    idle_input();
    checks++;
    if (acc_data !== 32'd5 || acc_cnt !== 8'd1) begin
      errors++;
      $display("FAIL hold_no_beats: data=%0d cnt=%0d required 5 1", acc_data, acc_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [27:0] exp28;
`ifdef CASE6_MAC_SATURATE_EN
    exp28 = 28'd134217727;
`else
    exp28 = 28'hFFFFFF0;
`endif
    for (int i = 0; i < 16; i++) send_beat(26'h1FFFFFF, 1'b0);
    idle_input();
    checks++;
    if (acc_vld28 !== 1'b1 || acc_data28 !== exp28 || acc_ovf28 !== 1'b1 || acc_cnt28 !== 8'd16) begin
      errors++;
      $display("FAIL ovf28: vld=%b data=%h ovf=%b cnt=%0d required 1 %h 1 16",
               acc_vld28, acc_data28, acc_ovf28, acc_cnt28, exp28);
    end
    checks++;
    if (acc_data !== 32'd536870896 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf32_none: data=%0d ovf=%b required 536870896 0", acc_data, acc_ovf);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 5; i++) send_beat(26'd9, 1'b0);
    idle_input();
    #2;
    ap_rst = 1'b1;
    #1;
    checks++;
    if ({acc_vld, acc_ovf, acc_cnt, acc_data, prod_rdy} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: vld=%b ovf=%b cnt=%0d data=%0d rdy=%b required all 0",
               acc_vld, acc_ovf, acc_cnt, acc_data, prod_rdy);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int i = 0; i < 16; i++) send_beat(26'd1, 1'b0);
    idle_input();
    checks++;
    if (acc_vld !== 1'b1 || acc_data !== 32'd16 || acc_cnt !== 8'd16 || acc_ovf !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: vld=%b data=%0d cnt=%0d ovf=%b required 1 16 16 0",
               acc_vld, acc_data, acc_cnt, acc_ovf);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_last_at_limit();
    for (int i = 0; i < 15; i++) send_beat(26'd3, 1'b0);
    send_beat(26'd3, 1'b1);
    idle_input();
    checks++;
    if (acc_vld !== 1'b1 || acc_data !== 32'd48 || acc_cnt !== 8'd16) begin
      errors++;
      $display("FAIL limit_result: vld=%b data=%0d cnt=%0d required 1 48 16",
               acc_vld, acc_data, acc_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge ap_clk);
      checks++;
      if (acc_vld !== 1'b0) begin
        errors++;
        $display("FAIL limit_single[%0d]: acc_vld=%b required 0", i, acc_vld);
      end
    end
    send_beat(26'd2, 1'b1);
    idle_input();
    checks++;
    if (acc_vld !== 1'b1 || acc_data !== 32'd2 || acc_cnt !== 8'd1) begin
      errors++;
      $display("FAIL limit_next_frame: vld=%b data=%0d cnt=%0d required 1 2 1",
               acc_vld, acc_data, acc_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_last_close();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    test_last_at_limit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
